// File: rtl/servo_frame_ctrl.sv
// Frame-synchronous duty controller feeding the PWM generator: clock divider, frame
// counter mirroring the generator, command holding register and per-frame duty slew.
module servo_frame_ctrl #(
  parameter int          HALF_DIV   = 25,
  parameter logic [11:0] ENDCOUNT   = 12'd1279,
  parameter logic [7:0]  RESET_DUTY = 8'd64,
  parameter int          LATCH_LEN  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_target,
  input  logic [3:0]  cmd_step,
  output logic        clockdiv,
  output logic        latch,
  output logic [7:0]  duty,
  output logic [11:0] endcount,
  output logic        busy
);

  localparam int DW = $clog2(HALF_DIV);
  localparam int LW = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_LATCH} state_t;
  typedef struct packed {
    logic [7:0] target;
    logic [3:0] step;
  } cmd_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          clockdiv_q, clockdiv_d;
  logic [11:0]   frame_cnt_q, frame_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic          latch_q, latch_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    target_q, target_d;
  logic [3:0]    step_q, step_d;
  cmd_t          hold_q, hold_d;
  logic          pending_q, pending_d;

  logic       div_wrap, tick, boundary, accept, load_hold;
  logic [7:0] gap, amt, slew_duty;

  // Divider and frame counter; a tick is the clockdiv rising edge
  always_comb begin
    div_wrap    = (div_cnt_q == DIV_LAST);
    tick        = div_wrap & ~clockdiv_q;
    boundary    = tick & (frame_cnt_q == ENDCOUNT);
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
    clockdiv_d  = clockdiv_q ^ div_wrap;
    frame_cnt_d = frame_cnt_q;
    if (tick) frame_cnt_d = (frame_cnt_q == ENDCOUNT) ? 12'd0 : frame_cnt_q + 12'd1;
  end

  // One slew step; amt never exceeds the gap, so no wrap past 0 or 255
  always_comb begin
    gap       = '0;
    amt       = '0;
    slew_duty = duty_q;
    if (step_q == 4'd0) begin
      slew_duty = target_q;
    end else if (target_q > duty_q) begin
      gap       = target_q - duty_q;
      amt       = (gap > {4'd0, step_q}) ? {4'd0, step_q} : gap;
      slew_duty = duty_q + amt;
    end else if (target_q < duty_q) begin
      gap       = duty_q - target_q;
      amt       = (gap > {4'd0, step_q}) ? {4'd0, step_q} : gap;
      slew_duty = duty_q - amt;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    duty_d    = duty_q;
    target_d  = target_q;
    step_d    = step_q;
    load_hold = 1'b0;
    case (state_q)
      S_IDLE: if (boundary) state_d = S_UPDATE;
      S_UPDATE: begin
        // duty uses the target in force before this cycle; a fresh target waits a frame
        duty_d    = slew_duty;
        load_hold = pending_q;
        if (pending_q) begin
          target_d = hold_q.target;
          step_d   = hold_q.step;
        end
        lat_cnt_d = '0;
        state_d   = S_LATCH;
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_LAST) state_d = S_IDLE;
        else lat_cnt_d = lat_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // latch trails the state by a cycle so duty is settled before its rising edge
  always_comb begin
    latch_d   = (state_q == S_LATCH);
    accept    = cmd_valid & ~pending_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    if (accept) begin
      hold_d    = '{target: cmd_target, step: cmd_step};
      pending_d = 1'b1;
    end else if (load_hold) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      clockdiv_q  <= 1'b0;
      frame_cnt_q <= '0;
      lat_cnt_q   <= '0;
      latch_q     <= 1'b0;
      duty_q      <= RESET_DUTY;
      target_q    <= RESET_DUTY;
      step_q      <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      clockdiv_q  <= clockdiv_d;
      frame_cnt_q <= frame_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      latch_q     <= latch_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
    end
  end

  assign cmd_ready = ~pending_q;
  assign clockdiv  = clockdiv_q;
  assign latch     = latch_q;
  assign duty      = duty_q;
  assign endcount  = ENDCOUNT;
  assign busy      = (duty_q != target_q) | pending_q;

endmodule
